// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: shares one can_tx between N_REQ requesters, lowest CAN id
// wins arbitration; watchdog aborts hung frames, gap enforced between frames.
module can_tx_scheduler #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int IFS_CYC     = 16,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [11*N_REQ-1:0] req_id,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ack,
    output logic               req_err,
    output logic               tx_start,
    output logic [10:0]        tx_id,
    output logic [7:0]         tx_data,
    input  logic               tx_done,
    output logic               busy,
    output logic [GW-1:0]      grant_idx
);

    localparam int TW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GPW = $clog2(IFS_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [10:0]     r_tx_id;
    logic [7:0]      r_tx_data;
    logic [GW-1:0]   r_grant;
    logic [TW-1:0]   r_timer;
    logic [GPW-1:0]  r_gap;
    logic            r_err;

    logic            w_found;
    logic [GW-1:0]   w_win_idx;
    logic [10:0]     w_win_id;
    logic [7:0]      w_win_data;
    logic            w_timeout;

    // Ascending scan with strict less-than keeps the lowest index on id ties
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_win_id   = '1;
        w_win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] &&
                (!w_found || req_id[11*i +: 11] < w_win_id)) begin
                w_found    = 1'b1;
                w_win_idx  = GW'(i);
                w_win_id   = req_id[11*i +: 11];
                w_win_data = req_data[8*i +: 8];
            end
        end
    end

    // Timer counts BUSY cycles; abort lands the ack TIMEOUT_CYC after tx_start
    assign w_timeout = (r_timer == TW'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_START;
            S_START: w_next = S_BUSY;
            S_BUSY:  if (tx_done || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_GAP;
            S_GAP:   if (r_gap == '0 && !tx_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_id   <= '0;
            r_tx_data <= '0;
            r_grant   <= '0;
            r_timer   <= '0;
            r_gap     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_tx_id   <= w_win_id;
                r_tx_data <= w_win_data;
                r_grant   <= w_win_idx;
            end
            if (r_state == S_START) begin
                r_timer <= '0;
            end else if (r_state == S_BUSY) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == S_BUSY && (tx_done || w_timeout)) begin
                r_err <= !tx_done;
            end
            if (r_state == S_DONE) begin
                r_gap <= GPW'(IFS_CYC - 1);
            end else if (r_state == S_GAP && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    always_comb begin
        tx_start = 1'b0;
        req_ack  = '0;
        req_err  = 1'b0;
        busy     = 1'b1;
        unique case (r_state)
            S_IDLE:  busy = 1'b0;
            S_START: tx_start = 1'b1;
            S_DONE: begin
                req_ack = N_REQ'(1) << r_grant;
                req_err = r_err;
            end
            default: ;
        endcase
    end

    assign tx_id     = r_tx_id;
    assign tx_data   = r_tx_data;
    assign grant_idx = r_grant;

endmodule
